paddle_engine: RTL
==================

# paddle_engine

Parametrised paddle controller for the 160x120, 3-bit-colour VGA adapter. A free-running frame timer paces each frame. On every frame tick the block samples the left/right controls. If the requested move is legal, it erases the paddle rectangle at its old position, updates the position with a configurable step and saturating bounds, and redraws the rectangle, one pixel per clock on the adapter's x/y/colour/plot port. Paddle width, height, row, step, bounds, colours and frame period are all parameters.

## Interface
- W, 16: paddle width in pixels (1..64)
- H, 2: paddle height in pixels (1..8)
- X_INIT, 72: x of left edge after reset
- Y_POS, 110: y of top row (fixed)
- X_MIN, 0: smallest legal left edge
- X_MAX, 159: largest legal right-edge pixel; the left edge never exceeds X_MAX-W+1
- STEP, 2: pixels moved per frame (1..15)
- FRAME_CYCLES, 833333: clocks per frame (60 Hz at 50 MHz); must exceed 2*W*H+4
- FG, 3'b111: paddle colour
- BG, 3'b000: erase colour
- clk  in  1  system clock (CLOCK_50)
- resetn  in  1  synchronous, active-low reset
- enable  in  1  1 = frames run; 0 = hold in IDLE
- left  in  1  move-left request, active high
- right  in  1  move-right request, active high
- x  out  8  pixel x to the VGA adapter
- y  out  7  pixel y to the VGA adapter
- colour  out  3  pixel colour
- plot  out  1  write strobe; one pixel per cycle while high
- paddle_x  out  8  current left-edge position
- busy  out  1  high in every state except IDLE
- frame_done  out  1  one-cycle pulse at the end of each serviced frame

## Operation
- States are INIT, DRAW, IDLE, ERASE, MOVE and DONE.
- Reset (resetn=0 at a clk edge) has these effects:
  - state=INIT, paddle_x=X_INIT, and the frame counter loads FRAME_CYCLES-1.
  - The scan counters and the pending flag clear.
  - Outputs: plot=0, x=0, y=0, colour=0, busy=0, frame_done=0.
- INIT lasts one cycle with plot=0, then goes to DRAW, so the paddle is painted at power-up.
- Frame counter behaviour:
  - It decrements every cycle.
  - At 0 it asserts tick for one cycle and reloads FRAME_CYCLES-1.
  - A tick sets the pending flag when enable=1. Ticks with enable=0 are discarded.
  - A tick while pending is already set is dropped, so there is no queueing.
- IDLE: if pending=1, clear pending and latch the direction.
  - right only: dir=+1.
  - left only: dir=-1.
  - both pressed or neither pressed: dir=0.
- Target position:
  - +1: min(paddle_x+STEP, X_MAX-W+1).
  - -1: X_MIN if paddle_x < X_MIN+STEP, otherwise paddle_x-STEP.
  - Compute in 9 bits so no intermediate value wraps.
- If the target equals paddle_x, go to DONE with no plotting. Otherwise go to ERASE.
- Scanning (ERASE and DRAW):
  - Counters cx=0..W-1 and cy=0..H-1, row-major with cx fastest.
  - x = paddle_x + cx, y = Y_POS + cy, plot=1 for exactly W*H cycles.
  - colour is BG in ERASE and FG in DRAW.
  - Counters reset to 0 on entry.
- MOVE: one cycle, plot=0; paddle_x <= target.
- Exits from DRAW:
  - after INIT: go to IDLE, no frame_done.
  - after MOVE: go to DONE.
- DONE: one cycle with frame_done=1 and plot=0, then IDLE.
- Dropping enable mid-frame does not abort the frame; it completes normally.
- When plot=0, x, y and colour hold their last values.

## Timing
- Outputs are decoded from the state and scan registers. A pixel appears in the same cycle the state/counters hold it.
- Tick cycle T (pending set) → IDLE samples at T+1 → ERASE begins at T+2.
- Moving frame sequence:
  - ERASE: W*H cycles.
  - MOVE: 1 cycle.
  - DRAW: W*H cycles.
  - DONE: 1 cycle.
  - busy is high for 2*W*H+2 cycles, and frame_done fires at T+2+2*W*H+1.
- Non-moving frame: DONE at T+2, busy high for 1 cycle, no plot.
- First tick after reset release is on cycle FRAME_CYCLES-1, counting the first released cycle as 0.
- Reset mid-operation: plot drops at the next edge. After release, INIT then a fresh DRAW at X_INIT follows. No erase of the stale paddle occurs; the system clear is responsible for that.

## Test plan
Base parameters for scenarios 1-4: W=4, H=2, STEP=2, X_INIT=10, Y_POS=100, FRAME_CYCLES=64.
1. Release reset → 8 plot cycles with colour 111, pixels (10..13, 100) then (10..13, 101); then IDLE with paddle_x=10 and frame_done never high.
2. Hold right through the tick → 8 BG pixels at x 10..13, one MOVE cycle, 8 FG pixels at x 12..15; frame_done pulses once; busy lasts 18 cycles; paddle_x=12.
3. Set X_INIT=1 and hold left for two frames → frame 1 erases at x 1..4 and draws at x 0..3 (paddle_x=0); frame 2 has no plot cycles but frame_done still pulses.
4. Set X_INIT=155, X_MAX=159 and hold right for two frames → move to paddle_x=156 (draws x 156..159); frame 2 does not plot.
5. Combined controls, enable and reset:
   - left and right both held → no plot and paddle_x unchanged.
   - enable=0 across three ticks → busy stays 0.
   - resetn=0 on the 3rd DRAW pixel of a moving frame → plot=0 on the next cycle; after release, the initial draw occurs at X_INIT.

Source files
------------

// File: rtl/paddle_engine_if.sv
// Control and VGA-adapter pixel signals of the paddle engine, grouped as one bundle.
// The master drives the paddle controls; the slave (the engine) drives the pixel port and status.
interface paddle_engine_if;
  logic       enable;
  logic       left;
  logic       right;
  logic [7:0] x;
  logic [6:0] y;
  logic [2:0] colour;
  logic       plot;
  logic [7:0] paddle_x;
  logic       busy;
  logic       frame_done;

  modport master (
    output enable, left, right,
    input  x, y, colour, plot, paddle_x, busy, frame_done
  );

  modport slave (
    input  enable, left, right,
    output x, y, colour, plot, paddle_x, busy, frame_done
  );
endinterface

// File: rtl/paddle_engine.sv
// Paddle controller for the 160x120 VGA adapter: a frame timer paces moves, and each
// move erases the old paddle rectangle and redraws it at the new position, one pixel per clock.
module paddle_engine #(
  parameter int          W            = 16,
  parameter int          H            = 2,
  parameter int          X_INIT       = 72,
  parameter int          Y_POS        = 110,
  parameter int          X_MIN        = 0,
  parameter int          X_MAX        = 159,
  parameter int          STEP         = 2,
  parameter int          FRAME_CYCLES = 833333,
  parameter logic [2:0]  FG           = 3'b111,
  parameter logic [2:0]  BG           = 3'b000
) (
  input  logic           clk,
  input  logic           resetn,
  paddle_engine_if.slave io_bus
);

  localparam int             FCW         = (FRAME_CYCLES > 1) ? $clog2(FRAME_CYCLES) : 1;
  localparam logic [FCW-1:0] L_RELOAD    = FCW'(FRAME_CYCLES - 1);
  localparam logic [8:0]     L_RIGHT_LIM = 9'(X_MAX - W + 1);
  localparam logic [8:0]     L_LEFT_THR  = 9'(X_MIN + STEP);
  localparam logic [8:0]     L_XMIN      = 9'(X_MIN);
  localparam logic [8:0]     L_STEP      = 9'(STEP);
  localparam logic [5:0]     L_CX_LAST   = 6'(W - 1);
  localparam logic [2:0]     L_CY_LAST   = 3'(H - 1);

  typedef enum logic [2:0] {
    S_INIT, S_DRAW, S_IDLE, S_ERASE, S_MOVE, S_DONE
  } state_t;

  state_t         r_state;
  logic [7:0]     r_paddle_x;
  logic [7:0]     r_target;
  logic [5:0]     r_cx;
  logic [2:0]     r_cy;
  logic           r_from_init;
  logic           r_pending;
  logic [FCW-1:0] r_frame_cnt;
  logic [7:0]     r_x_last;
  logic [6:0]     r_y_last;
  logic [2:0]     r_col_last;

  logic       w_tick;
  logic       w_plot;
  logic       w_last_pix;
  logic [8:0] w_px9;
  logic [8:0] w_plus;
  logic [8:0] w_tgt_right;
  logic [8:0] w_tgt_left;
  logic [8:0] w_target;
  logic [7:0] w_pix_x;
  logic [6:0] w_pix_y;
  logic [2:0] w_pix_col;

  assign w_tick = (r_frame_cnt == '0);

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_frame_cnt <= L_RELOAD;
    end else if (w_tick) begin
      r_frame_cnt <= L_RELOAD;
    end else begin
      r_frame_cnt <= r_frame_cnt - 1'b1;
    end
  end

  // A tick arriving while a request is still outstanding is dropped, not queued.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_pending <= 1'b0;
    end else if (r_state == S_IDLE && r_pending) begin
      r_pending <= 1'b0;
    end else if (w_tick && io_bus.enable) begin
      r_pending <= 1'b1;
    end
  end

  // Nine-bit arithmetic keeps paddle_x+STEP and paddle_x-STEP from wrapping.
  assign w_px9       = {1'b0, r_paddle_x};
  assign w_plus      = w_px9 + L_STEP;
  assign w_tgt_right = (w_plus > L_RIGHT_LIM) ? L_RIGHT_LIM : w_plus;
  assign w_tgt_left  = (w_px9 < L_LEFT_THR) ? L_XMIN : (w_px9 - L_STEP);

  always_comb begin
    w_target = w_px9;
    if (io_bus.right && !io_bus.left) begin
      w_target = w_tgt_right;
    end else if (io_bus.left && !io_bus.right) begin
      w_target = w_tgt_left;
    end
  end

  assign w_last_pix = (r_cx == L_CX_LAST) && (r_cy == L_CY_LAST);
  assign w_plot     = (r_state == S_ERASE) || (r_state == S_DRAW);
  assign w_pix_x    = r_paddle_x + {2'b00, r_cx};
  assign w_pix_y    = 7'(Y_POS) + {4'b0000, r_cy};
  assign w_pix_col  = (r_state == S_ERASE) ? BG : FG;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_state     <= S_INIT;
      r_paddle_x  <= 8'(X_INIT);
      r_target    <= 8'(X_INIT);
      r_cx        <= '0;
      r_cy        <= '0;
      r_from_init <= 1'b1;
      r_x_last    <= '0;
      r_y_last    <= '0;
      r_col_last  <= '0;
    end else begin
      if (w_plot) begin
        r_x_last   <= w_pix_x;
        r_y_last   <= w_pix_y;
        r_col_last <= w_pix_col;
      end
      case (r_state)
        S_INIT: begin
          r_cx        <= '0;
          r_cy        <= '0;
          r_from_init <= 1'b1;
          r_state     <= S_DRAW;
        end
        S_IDLE: begin
          if (r_pending) begin
            r_target    <= w_target[7:0];
            r_from_init <= 1'b0;
            r_state     <= (w_target == w_px9) ? S_DONE : S_ERASE;
          end
        end
        S_ERASE, S_DRAW: begin
          if (w_last_pix) begin
            r_cx <= '0;
            r_cy <= '0;
            if (r_state == S_ERASE) begin
              r_state <= S_MOVE;
            end else if (r_from_init) begin
              r_state <= S_IDLE;
            end else begin
              r_state <= S_DONE;
            end
          end else if (r_cx == L_CX_LAST) begin
            r_cx <= '0;
            r_cy <= r_cy + 3'd1;
          end else begin
            r_cx <= r_cx + 6'd1;
          end
        end
        S_MOVE: begin
          r_paddle_x <= r_target;
          r_state    <= S_DRAW;
        end
        S_DONE: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_INIT;
        end
      endcase
    end
  end

  // INIT only exists as the post-reset cycle, where busy must still read low.
  assign io_bus.busy       = (r_state != S_IDLE) && (r_state != S_INIT);
  assign io_bus.frame_done = (r_state == S_DONE);
  assign io_bus.plot       = w_plot;
  assign io_bus.x          = w_plot ? w_pix_x : r_x_last;
  assign io_bus.y          = w_plot ? w_pix_y : r_y_last;
  assign io_bus.colour     = w_plot ? w_pix_col : r_col_last;
  assign io_bus.paddle_x   = r_paddle_x;

endmodule
